// File: rtl/mem_resp_model_if.sv
// Request/response bus between cache_fsm (master) and mem_resp_model (slave).
// One 128-bit line moves per transaction.
interface mem_resp_model_if;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;     // 1 = write-back, 0 = allocate (read)
        logic         valid;
    } mem_req_type;

    typedef struct packed {
        logic [127:0] data;
        logic         ready;
    } mem_data_type;

    mem_req_type  mem_req;
    mem_data_type mem_data;

    modport master (output mem_req, input  mem_data);
    modport slave  (input  mem_req, output mem_data);

endinterface

// File: rtl/mem_resp_model.sv
// Line-granular main-memory responder with programmable read/write latency.
// Define MEM_RAND_LAT_EN to add 0..3 LFSR-driven extra wait cycles per request.
module mem_resp_model #(
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int RD_LAT = 2,
    parameter int WB_LAT = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    mem_resp_model_if.slave         bus,
    output logic [31:0]             rd_cnt,
    output logic [31:0]             wr_cnt,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, DONE} state_t;

    state_t             state;
    logic [8:0]         cnt;
    logic [8:0]         lat_sel;
    logic [IDX_W-1:0]   new_idx;
    logic [IDX_W-1:0]   req_idx;
    logic [127:0]       req_data;
    logic               req_rw;
    logic [DEPTH-1:0]   written;
    logic [127:0]       store [DEPTH];

    // Upper address bits and the byte offset alias onto the same line.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.mem_req.addr[31:IDX_W+4], bus.mem_req.addr[3:0]};

`ifdef MEM_RAND_LAT_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
`endif

    always_comb begin
        new_idx = bus.mem_req.addr[IDX_W+3:4];
        lat_sel = bus.mem_req.rw ? 9'(WB_LAT) : 9'(RD_LAT);
`ifdef MEM_RAND_LAT_EN
        lat_sel = lat_sel + 9'(lfsr[1:0]);
`endif
    end

    function automatic logic [127:0] read_line(input logic [IDX_W-1:0] idx, input logic rw);
        return (!rw && written[idx]) ? store[idx] : 128'h0;
    endfunction

    // NOTE: state uses non-blocking assignments so every branch sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= '0;
            req_idx           <= '0;
            req_data          <= '0;
            req_rw            <= 1'b0;
            written           <= '0;
            rd_cnt            <= '0;
            wr_cnt            <= '0;
            busy              <= 1'b0;
            bus.mem_data      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mem_req.valid) begin
                        req_idx  <= new_idx;
                        req_data <= bus.mem_req.data;
                        req_rw   <= bus.mem_req.rw;
                        cnt      <= lat_sel;
                        busy     <= 1'b1;
                        if (lat_sel == 9'd0) begin
                            state              <= RESP;
                            bus.mem_data.ready <= 1'b1;
                            bus.mem_data.data  <= read_line(new_idx, bus.mem_req.rw);
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 9'd1) begin
                        state              <= RESP;
                        bus.mem_data.ready <= 1'b1;
                        bus.mem_data.data  <= read_line(req_idx, req_rw);
                    end else begin
                        cnt <= cnt - 9'd1;
                    end
                end
                RESP: begin
                    state        <= DONE;
                    bus.mem_data <= '0;
                    if (req_rw) begin
                        written[req_idx] <= 1'b1;
                        wr_cnt           <= wr_cnt + 32'd1;
                    end else begin
                        rd_cnt <= rd_cnt + 32'd1;
                    end
                end
                default: begin
                    // DONE: one dead cycle so cache_fsm can switch requests.
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the line store has no reset; the written flags make stale contents invisible.
    always_ff @(posedge clk) begin
        if (!rst && state == RESP && req_rw)
            store[req_idx] <= req_data;
    end

endmodule

// File: tb/tb_mem_resp_model.sv
// Self-checking bench for mem_resp_model: directed plan plus randomized traffic
// against a transaction-level reference store.
module tb_mem_resp_model;

    localparam int DEPTH  = 256;
    localparam int IDX_W  = 8;
    localparam int RD_LAT = 2;
    localparam int WB_LAT = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rd_cnt, wr_cnt;
    logic        busy;

    mem_resp_model_if bus();

    mem_resp_model #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .WB_LAT(WB_LAT)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .rd_cnt (rd_cnt),
        .wr_cnt (wr_cnt),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_ready_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: set of written lines plus transaction counts.
    logic [127:0] ref_mem [int];
    int unsigned  ref_rd = 0;
    int unsigned  ref_wr = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ref_mem.delete();
        ref_rd = 0;
        ref_wr = 0;
    endtask

    task automatic txn(input logic [31:0] addr, input logic [127:0] wdata, input logic rw,
                       input bit drop, input bit hold);
        int idx, lat, k;
        logic [127:0] exp_d;
        logic [31:0] r;
        idx   = int'(addr[IDX_W+3:4]);
        lat   = rw ? WB_LAT : RD_LAT;
        exp_d = (!rw && ref_mem.exists(idx)) ? ref_mem[idx] : 128'h0;

        bus.mem_req.addr  = addr;
        bus.mem_req.data  = wdata;
        bus.mem_req.rw    = rw;
        bus.mem_req.valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (drop) begin
            r = $urandom();
            bus.mem_req.valid = 1'b0;
            bus.mem_req.addr  = r;
            bus.mem_req.rw    = r[7];
            bus.mem_req.data  = {4{$urandom()}};
        end

        k = 1;
        while (bus.mem_data.ready !== 1'b1 && k <= lat + 8) begin
            check("wait_data", bus.mem_data.data, 128'h0);
            @(negedge clk);
            k++;
        end
        check("ready_cycle", 128'(k), 128'(lat + 1));
        check("resp_data", bus.mem_data.data, exp_d);
        last_ready_cyc = cyc;

        if (rw) begin
            ref_mem[idx] = wdata;
            ref_wr++;
        end else begin
            ref_rd++;
        end

        // cache_fsm style: keep valid high and flip to a read while DONE ignores it.
        if (hold) bus.mem_req.rw = 1'b0;
        else      bus.mem_req.valid = 1'b0;

        @(negedge clk);
        check("done_ready", 128'(bus.mem_data.ready), 128'h0);
        check("done_data", bus.mem_data.data, 128'h0);
        check("done_busy", 128'(busy), 128'h1);
        check("rd_cnt", 128'(rd_cnt), 128'(ref_rd));
        check("wr_cnt", 128'(wr_cnt), 128'(ref_wr));
        @(negedge clk);
        check("idle_busy", 128'(busy), 128'h0);
        bus.mem_req.valid = 1'b0;
    endtask

    initial begin
        int t_first;
        bit any_ready;
        logic [31:0] r;
        logic [IDX_W-1:0] ridx;

        bus.mem_req = '0;
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ready", 128'(bus.mem_data.ready), 128'h0);
        check("rst_data", bus.mem_data.data, 128'h0);
        check("rst_rd_cnt", 128'(rd_cnt), 128'h0);
        check("rst_wr_cnt", 128'(wr_cnt), 128'h0);
        check("rst_busy", 128'(busy), 128'h0);
        rst = 1'b0;
        @(negedge clk);

        // Unwritten line reads as zero.
        txn(32'h0000_0010, 128'h0, 1'b0, 1'b0, 1'b0);

        // Write then read back.
        txn(32'h1111_0010, {4{32'hABCDABCD}}, 1'b1, 1'b0, 1'b0);
        txn(32'h1111_0010, 128'h0, 1'b0, 1'b0, 1'b0);
        check("rb_value", ref_mem[1], {4{32'hABCDABCD}});

        // Write-back immediately followed by allocate, valid held through DONE.
        txn(32'h2222_0010, {4{32'h11111111}}, 1'b1, 1'b0, 1'b1);
        t_first = last_ready_cyc;
        txn(32'h3333_0020, 128'h0, 1'b0, 1'b0, 1'b0);
        check("b2b_gap", 128'(last_ready_cyc - t_first), 128'(RD_LAT + 3));

        // Aliasing: different upper bits, same line index.
        txn(32'h4444_0010, {4{32'hDEADDEAD}}, 1'b1, 1'b0, 1'b0);
        txn(32'h5555_0010, 128'h0, 1'b0, 1'b0, 1'b0);

        // valid dropped and fields scrambled one cycle after acceptance.
        txn(32'h5555_001C, 128'h0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic over a few aliased lines.
        for (int i = 0; i < 14; i++) begin
            r    = $urandom();
            ridx = IDX_W'($urandom_range(0, 3));
            txn({r[31:12], ridx, r[3:0]}, {$urandom(), $urandom(), $urandom(), $urandom()},
                r[4], r[5], r[6]);
        end

        // Reset in the middle of a write's wait period drops it entirely.
        bus.mem_req.addr  = 32'h6666_0030;
        bus.mem_req.data  = {4{32'hFEEDFACE}};
        bus.mem_req.rw    = 1'b1;
        bus.mem_req.valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.mem_req.valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_busy", 128'(busy), 128'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        any_ready = 1'b0;
        for (int i = 0; i < WB_LAT + 4; i++) begin
            if (bus.mem_data.ready === 1'b1) any_ready = 1'b1;
            @(negedge clk);
        end
        check("mid_no_ready", 128'(any_ready), 128'h0);
        check("mid_wr_cnt", 128'(wr_cnt), 128'h0);
        check("mid_rd_cnt", 128'(rd_cnt), 128'h0);
        check("mid_busy_low", 128'(busy), 128'h0);
        txn(32'h6666_0030, 128'h0, 1'b0, 1'b0, 1'b0);
        // Flags cleared by reset: the earlier aliased line also reads zero.
        txn(32'h4444_0010, 128'h0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
